// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and the serial PRBS checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAPS = 8'b1100_1001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/lfsr_next_bit.sv
// Combinational feedback bit of the 8-bit LFSR: XOR of the tapped register bits.
module lfsr_next_bit
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_sr,
  output logic              o_p
);

  assign o_p = ^(i_sr & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker: hunts, verifies, then flywheels on its
// own predictions while counting bit errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_o
);

  localparam logic [3:0] FILL_FULL = 4'(LFSR_W);
  localparam logic [7:0] LOCK_THR  = 8'(LOCK_CNT);
  localparam logic [3:0] LOSS_THR  = 4'(LOSS_CNT);

  chk_state_t        r_state, w_state_nxt;
  logic [LFSR_W-1:0] r_sr, w_sr_nxt;
  logic [3:0]        r_fill, w_fill_nxt;
  logic [7:0]        r_match, w_match_nxt;
  logic [3:0]        r_loss, w_loss_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_err, w_err_nxt;
  logic [CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;
  logic              w_p;

  lfsr_next_bit u_next_bit (
    .i_sr (r_sr),
    .o_p  (w_p)
  );

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state   <= HUNT;
      r_sr      <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_loss    <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_fill    <= w_fill_nxt;
      r_match   <= w_match_nxt;
      r_loss    <= w_loss_nxt;
      r_locked  <= w_locked_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_fill_nxt    = r_fill;
    w_match_nxt   = r_match;
    w_loss_nxt    = r_loss;
    w_locked_nxt  = r_locked;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = r_err_cnt;

    if (bit_vld) begin
      case (r_state)
        HUNT: begin
          w_sr_nxt = {bit_in, r_sr[LFSR_W-1:1]};
          if (r_fill != FILL_FULL) w_fill_nxt = r_fill + 4'd1;
          // All-zero contents are the LFSR lockup state; keep shifting until a one arrives.
          if ((w_fill_nxt == FILL_FULL) && (w_sr_nxt != '0)) begin
            w_state_nxt = VERIFY;
            w_match_nxt = '0;
          end
        end
        VERIFY: begin
          w_sr_nxt = {bit_in, r_sr[LFSR_W-1:1]};
          if (bit_in == w_p) begin
            w_match_nxt = r_match + 8'd1;
            if (w_match_nxt == LOCK_THR) begin
              w_state_nxt  = LOCKED;
              w_loss_nxt   = '0;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_match_nxt = '0;
          end
          if (w_sr_nxt == '0) begin
            w_state_nxt  = HUNT;
            w_fill_nxt   = '0;
            w_locked_nxt = 1'b0;
          end
        end
        LOCKED: begin
          // Flywheel: the shadow register follows its own prediction, not the line.
          w_sr_nxt = {w_p, r_sr[LFSR_W-1:1]};
          if (bit_in != w_p) begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 1'b1;
            w_loss_nxt = r_loss + 4'd1;
            if (w_loss_nxt == LOSS_THR) begin
              w_state_nxt  = HUNT;
              w_fill_nxt   = '0;
              w_locked_nxt = 1'b0;
            end
          end else begin
            w_loss_nxt = '0;
          end
        end
        default: begin
          w_state_nxt  = HUNT;
          w_fill_nxt   = '0;
          w_locked_nxt = 1'b0;
        end
      endcase
    end

    if (cnt_clr) w_err_cnt_nxt = '0;
  end

  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign state_o = r_state;

endmodule
